rc5_sram_scheduler: RTL and testbench

Phase sequencer and S-table RAM arbiter for the RC5 core. Accepts host job requests (encrypt, decrypt, round-trip), runs key expansion when the key table is stale, then issues start pulses to the cipher and decipher engines in order. It multiplexes the shared dual-port S RAM so exactly one engine owns it at a time. It replaces ad-hoc done→start flip-flop chains and address muxing at the top level.

---
 rtl/rc5_sram_scheduler_pkg.sv | 62 ++++++
 rtl/rc5_sram_port_mux.sv | 49 ++++
 rtl/rc5_sram_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_rc5_sram_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rc5_sram_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rc5_sram_scheduler_pkg
// Brief    : Shared types and constants for the RC5 phase sequencer and
//            S-table RAM arbiter (state encoding, owner/mode codes, sizing).
// Revision : 1.0  initial release
// ============================================================================
package rc5_sram_scheduler_pkg;

  // Datapath width of the RC5 core; RAM data never passes the arbiter
  localparam int W_DEF = 32;
  // Default round count
  localparam int R_DEF = 12;

  // Number of S-table words for a given round count
  function automatic int t_of(input int rounds);
    return 2 * (rounds + 1);
  endfunction

  // S-RAM address width for a given round count
  function automatic int t_length_of(input int rounds);
    return $clog2(t_of(rounds));
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EXP_WAIT  = 3'd1,
    ST_EXP_RUN   = 3'd2,
    ST_CIPH_WAIT = 3'd3,
    ST_CIPH_RUN  = 3'd4,
    ST_DEC_WAIT  = 3'd5,
    ST_DEC_RUN   = 3'd6,
    ST_FINISH    = 3'd7
  } state_t;

  // RAM owner codes
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_EXP  = 2'd1;
  localparam logic [1:0] OWN_CIPH = 2'd2;
  localparam logic [1:0] OWN_DEC  = 2'd3;

  // Host job modes
  localparam logic [1:0] MODE_ENC  = 2'b00;
  localparam logic [1:0] MODE_DEC  = 2'b01;
  localparam logic [1:0] MODE_RT   = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  // Last count value of the two-cycle WAIT hold
  localparam logic [1:0] WAIT_LAST = 2'd1;

  // Engine that owns the RAM in a given state
  function automatic logic [1:0] owner_of(input state_t s);
    case (s)
      ST_EXP_WAIT,  ST_EXP_RUN:  return OWN_EXP;
      ST_CIPH_WAIT, ST_CIPH_RUN: return OWN_CIPH;
      ST_DEC_WAIT,  ST_DEC_RUN:  return OWN_DEC;
      default:                   return OWN_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rc5_sram_port_mux.sv
`default_nettype none
// ============================================================================
// Module   : rc5_sram_port_mux
// Brief    : Combinational owner-to-port multiplexer for the shared S RAM.
//            Only the current owner's addresses reach the RAM; the expander
//            is the only engine allowed to write.
// Revision : 1.0  initial release
// ============================================================================
module rc5_sram_port_mux
  import rc5_sram_scheduler_pkg::*;
#(
  parameter int T_LENGTH = t_length_of(R_DEF)
) (
  input  logic [1:0]          owner,
  input  logic [T_LENGTH-1:0] addr_exp,
  input  logic                we_exp,
  input  logic [T_LENGTH-1:0] addr_ciph1,
  input  logic [T_LENGTH-1:0] addr_ciph2,
  input  logic [T_LENGTH-1:0] addr_dec1,
  input  logic [T_LENGTH-1:0] addr_dec2,
  output logic [T_LENGTH-1:0] addr_a,
  output logic [T_LENGTH-1:0] addr_b,
  output logic                we_a
);

  // Route the owning engine's requests; unowned RAM sees all zeros
  always_comb begin
    addr_a = '0;
    addr_b = '0;
    we_a   = 1'b0;
    case (owner)
      OWN_EXP: begin
        addr_a = addr_exp;
        we_a   = we_exp;
      end
      OWN_CIPH: begin
        addr_a = addr_ciph1;
        addr_b = addr_ciph2;
      end
      OWN_DEC: begin
        addr_a = addr_dec1;
        addr_b = addr_dec2;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rc5_sram_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rc5_sram_scheduler
// Brief    : RC5 phase sequencer. Runs key expansion when the S table is
//            stale, then starts cipher and/or decipher engines in order while
//            granting the shared S RAM to exactly one engine at a time.
// Revision : 1.0  initial release
// ============================================================================
module rc5_sram_scheduler
  import rc5_sram_scheduler_pkg::*;
#(
  parameter int R        = R_DEF,
  parameter int T_LENGTH = t_length_of(R)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iStart,
  input  logic [1:0]          iMode,
  input  logic                iRekey,
  output logic                oBusy,
  output logic                oDone,
  output logic                oError,
  output logic                oKeyValid,
  output logic [1:0]          oOwner,
  output logic                oExpandStart,
  output logic                oCipherStart,
  output logic                oDecipherStart,
  input  logic                iExpandDone,
  input  logic                iCipherDone,
  input  logic                iDecipherDone,
  input  logic [T_LENGTH-1:0] iS_addr_exp,
  input  logic                iS_we_exp,
  input  logic [T_LENGTH-1:0] iS_addr_ciph1,
  input  logic [T_LENGTH-1:0] iS_addr_ciph2,
  input  logic [T_LENGTH-1:0] iS_addr_dec1,
  input  logic [T_LENGTH-1:0] iS_addr_dec2,
  output logic [T_LENGTH-1:0] oS_addr_a,
  output logic [T_LENGTH-1:0] oS_addr_b,
  output logic                oS_we_a
);

  state_t     state,      state_next;
  logic [1:0] wait_cnt,   wait_cnt_next;
  logic [1:0] mode,       mode_next;
  logic [1:0] owner,      owner_next;
  logic       key_valid,  key_valid_next;
  logic       exp_start,  exp_start_next;
  logic       ciph_start, ciph_start_next;
  logic       dec_start,  dec_start_next;
  logic       error,      error_next;
  logic       stray_done;

  // Next-state, counter, key-valid, start-pulse and error decode
  always_comb begin
    state_next      = state;
    wait_cnt_next   = '0;
    mode_next       = mode;
    key_valid_next  = key_valid;
    exp_start_next  = 1'b0;
    ciph_start_next = 1'b0;
    dec_start_next  = 1'b0;

    // A done from anyone but the RAM owner is dropped and flagged
    stray_done = (iExpandDone   && (owner != OWN_EXP))  ||
                 (iCipherDone   && (owner != OWN_CIPH)) ||
                 (iDecipherDone && (owner != OWN_DEC));
    error_next = stray_done;

    case (state)
      ST_IDLE: begin
        if (iStart) begin
          if (iMode == MODE_RSVD) begin
            error_next = 1'b1;
          end else begin
            mode_next = iMode;
            if (iRekey || !key_valid) begin
              state_next     = ST_EXP_WAIT;
              key_valid_next = 1'b0;
            end else if (iMode == MODE_DEC) begin
              state_next = ST_DEC_WAIT;
            end else begin
              state_next = ST_CIPH_WAIT;
            end
          end
        end
      end
      ST_EXP_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_next     = ST_EXP_RUN;
          exp_start_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 2'd1;
        end
      end
      ST_CIPH_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_next      = ST_CIPH_RUN;
          ciph_start_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 2'd1;
        end
      end
      ST_DEC_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_next     = ST_DEC_RUN;
          dec_start_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 2'd1;
        end
      end
      ST_EXP_RUN: begin
        if (iExpandDone) begin
          key_valid_next = 1'b1;
          state_next     = (mode == MODE_DEC) ? ST_DEC_WAIT : ST_CIPH_WAIT;
        end
      end
      ST_CIPH_RUN: begin
        if (iCipherDone) begin
          state_next = (mode == MODE_RT) ? ST_DEC_WAIT : ST_FINISH;
        end
      end
      ST_DEC_RUN: begin
        if (iDecipherDone) begin
          state_next = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Ownership follows the state being entered so the mux is registered-driven
    owner_next = owner_of(state_next);
  end

  // State, counter and registered outputs; reset returns everything to idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      mode       <= MODE_ENC;
      owner      <= OWN_NONE;
      key_valid  <= 1'b0;
      exp_start  <= 1'b0;
      ciph_start <= 1'b0;
      dec_start  <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_cnt_next;
      mode       <= mode_next;
      owner      <= owner_next;
      key_valid  <= key_valid_next;
      exp_start  <= exp_start_next;
      ciph_start <= ciph_start_next;
      dec_start  <= dec_start_next;
      error      <= error_next;
    end
  end

  assign oBusy          = (state != ST_IDLE);
  assign oDone          = (state == ST_FINISH);
  assign oError         = error;
  assign oKeyValid      = key_valid;
  assign oOwner         = owner;
  assign oExpandStart   = exp_start;
  assign oCipherStart   = ciph_start;
  assign oDecipherStart = dec_start;

  rc5_sram_port_mux #(
    .T_LENGTH (T_LENGTH)
  ) u_port_mux (
    .owner      (owner),
    .addr_exp   (iS_addr_exp),
    .we_exp     (iS_we_exp),
    .addr_ciph1 (iS_addr_ciph1),
    .addr_ciph2 (iS_addr_ciph2),
    .addr_dec1  (iS_addr_dec1),
    .addr_dec2  (iS_addr_dec2),
    .addr_a     (oS_addr_a),
    .addr_b     (oS_addr_b),
    .we_a       (oS_we_a)
  );

endmodule
`default_nettype wire

// File: tb/tb_rc5_sram_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc5_sram_scheduler
// Brief    : Self-checking bench for rc5_sram_scheduler. Jobs are expanded
//            into an expected per-cycle timeline from the phase rules, then
//            driven and compared cycle by cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_rc5_sram_scheduler;

  localparam int TL = 5;

  logic          clk;
  logic          rst;
  logic          iStart, iRekey;
  logic [1:0]    iMode;
  logic          oBusy, oDone, oError, oKeyValid;
  logic [1:0]    oOwner;
  logic          oExpandStart, oCipherStart, oDecipherStart;
  logic          iExpandDone, iCipherDone, iDecipherDone;
  logic [TL-1:0] iS_addr_exp, iS_addr_ciph1, iS_addr_ciph2, iS_addr_dec1, iS_addr_dec2;
  logic          iS_we_exp;
  logic [TL-1:0] oS_addr_a, oS_addr_b;
  logic          oS_we_a;

  rc5_sram_scheduler dut (
    .clk(clk), .rst(rst),
    .iStart(iStart), .iMode(iMode), .iRekey(iRekey),
    .oBusy(oBusy), .oDone(oDone), .oError(oError), .oKeyValid(oKeyValid),
    .oOwner(oOwner),
    .oExpandStart(oExpandStart), .oCipherStart(oCipherStart),
    .oDecipherStart(oDecipherStart),
    .iExpandDone(iExpandDone), .iCipherDone(iCipherDone),
    .iDecipherDone(iDecipherDone),
    .iS_addr_exp(iS_addr_exp), .iS_we_exp(iS_we_exp),
    .iS_addr_ciph1(iS_addr_ciph1), .iS_addr_ciph2(iS_addr_ciph2),
    .iS_addr_dec1(iS_addr_dec1), .iS_addr_dec2(iS_addr_dec2),
    .oS_addr_a(oS_addr_a), .oS_addr_b(oS_addr_b), .oS_we_a(oS_we_a)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic kv_model = 1'b0;

  // One expected cycle of a job: outputs to see and done inputs to drive
  typedef struct {
    logic       busy, done, err, kv;
    logic [1:0] owner;
    logic       st_e, st_c, st_d;
    logic       dn_e, dn_c, dn_d;
  } cyc_t;
  cyc_t tl[$];

  // Table of whole jobs with hand-computed busy length and key state after
  typedef struct {
    logic [1:0] mode;
    logic       rekey;
    int         lat;
    int         busy;
    logic       kv;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Expected RAM port values for a given owner and current engine requests
  function automatic logic [2*TL:0] mux_ref(input logic [1:0] own);
    case (own)
      2'd1:    return {iS_addr_exp, {TL{1'b0}}, iS_we_exp};
      2'd2:    return {iS_addr_ciph1, iS_addr_ciph2, 1'b0};
      2'd3:    return {iS_addr_dec1, iS_addr_dec2, 1'b0};
      default: return '0;
    endcase
  endfunction

  task automatic rand_addrs();
    iS_addr_exp   = TL'($urandom_range(0, 25));
    iS_we_exp     = 1'($urandom_range(0, 1));
    iS_addr_ciph1 = TL'($urandom_range(0, 25));
    iS_addr_ciph2 = TL'($urandom_range(0, 25));
    iS_addr_dec1  = TL'($urandom_range(0, 25));
    iS_addr_dec2  = TL'($urandom_range(0, 25));
  endtask

  // Expand a job into its per-cycle expectation from the phase rules
  task automatic build(input logic [1:0] m, input logic rk, input int le, input int lc, input int ld);
    cyc_t c;
    int   eng[$];
    int   lat;
    tl.delete();
    c = '{default: 1'b0};
    if (m == 2'b11) begin
      c.err = 1'b1; c.kv = kv_model; tl.push_back(c);
      c.err = 1'b0; tl.push_back(c);
      return;
    end
    if (rk || !kv_model) begin
      eng.push_back(1);
      kv_model = 1'b0;
    end
    if (m != 2'b01) eng.push_back(2);
    if (m != 2'b00) eng.push_back(3);
    foreach (eng[i]) begin
      lat = (eng[i] == 1) ? le : (eng[i] == 2) ? lc : ld;
      // two hold cycles, then the run with the start pulse in its first cycle
      for (int j = 0; j < 3 + lat; j++) begin
        c = '{default: 1'b0};
        c.busy = 1'b1; c.kv = kv_model; c.owner = 2'(eng[i]);
        if (j == 2) begin
          c.st_e = (eng[i] == 1); c.st_c = (eng[i] == 2); c.st_d = (eng[i] == 3);
        end
        if (j == 2 + lat) begin
          c.dn_e = (eng[i] == 1); c.dn_c = (eng[i] == 2); c.dn_d = (eng[i] == 3);
        end
        tl.push_back(c);
      end
      if (eng[i] == 1) kv_model = 1'b1;
    end
    c = '{default: 1'b0};
    c.busy = 1'b1; c.done = 1'b1; c.kv = kv_model; tl.push_back(c);
    c.busy = 1'b0; c.done = 1'b0; tl.push_back(c);
  endtask

  // Issue one job and compare every cycle; noise adds ignored iStart while busy
  task automatic run_job(input logic [1:0] m, input logic rk, input int le, input int lc,
                         input int ld, input logic noise, output int busy_cnt);
    logic [8:0] act, exp;
    build(m, rk, le, lc, ld);
    iStart = 1'b1; iMode = m; iRekey = rk;
    busy_cnt = 0;
    foreach (tl[i]) begin
      @(negedge clk);
      iStart = noise && tl[i].busy && ($urandom_range(0, 1) == 1);
      iMode  = 2'($urandom_range(0, 3));
      iRekey = 1'($urandom_range(0, 1));
      iExpandDone = tl[i].dn_e; iCipherDone = tl[i].dn_c; iDecipherDone = tl[i].dn_d;
      rand_addrs();
      #1;
      act = {oBusy, oDone, oError, oKeyValid, oOwner, oExpandStart, oCipherStart, oDecipherStart};
      exp = {tl[i].busy, tl[i].done, tl[i].err, tl[i].kv, tl[i].owner,
             tl[i].st_e, tl[i].st_c, tl[i].st_d};
      chk("job_ctrl", {23'd0, act}, {23'd0, exp});
      chk("job_mux", {21'd0, oS_addr_a, oS_addr_b, oS_we_a}, {21'd0, mux_ref(tl[i].owner)});
      if (oBusy) busy_cnt++;
    end
    iStart = 1'b0; iRekey = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got timeout expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    vt[0] = '{2'b00, 1'b0,  4, 15, 1'b1};  // stale key: expand then encrypt
    vt[1] = '{2'b10, 1'b0, 30, 67, 1'b1};  // round trip, no expansion
    vt[2] = '{2'b11, 1'b1,  0,  0, 1'b1};  // reserved: error only, key kept
    vt[3] = '{2'b01, 1'b0,  0,  4, 1'b1};  // decrypt, done with start pulse
    vt[4] = '{2'b01, 1'b1,  2, 11, 1'b1};  // forced rekey then decrypt
    vt[5] = '{2'b00, 1'b0,  0,  4, 1'b1};  // minimum encrypt

    rst = 1'b0; iStart = 1'b0; iMode = 2'b00; iRekey = 1'b0;
    iExpandDone = 1'b0; iCipherDone = 1'b0; iDecipherDone = 1'b0;
    rand_addrs();
    @(negedge clk); @(negedge clk); #1;
    chk("reset_ctrl", {23'd0, oBusy, oDone, oError, oKeyValid, oOwner,
                       oExpandStart, oCipherStart, oDecipherStart}, 32'd0);
    chk("reset_mux", {21'd0, oS_addr_a, oS_addr_b, oS_we_a}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vt[i]) begin
      run_job(vt[i].mode, vt[i].rekey, vt[i].lat, vt[i].lat, vt[i].lat, 1'b0, bc);
      chk("table_busy_len", bc, vt[i].busy);
      chk("table_kv_after", {31'd0, oKeyValid}, {31'd0, vt[i].kv});
    end

    // Stray cipher done while decipher owns the RAM
    iStart = 1'b1; iMode = 2'b01; iRekey = 1'b0;
    @(negedge clk); iStart = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("dec_start", {31'd0, oDecipherStart}, 32'd1);
    @(negedge clk);
    iCipherDone = 1'b1; iS_addr_dec1 = 5'd9; iS_addr_dec2 = 5'd11; #1;
    chk("dec_ports", {21'd0, oS_addr_a, oS_addr_b, oS_we_a}, {21'd0, 5'd9, 5'd11, 1'b0});
    @(negedge clk); iCipherDone = 1'b0; #1;
    chk("stray_err", {28'd0, oError, oBusy, oOwner}, {28'd0, 1'b1, 1'b1, 2'd3});
    chk("stray_ports", {21'd0, oS_addr_a, oS_addr_b, oS_we_a}, {21'd0, 5'd9, 5'd11, 1'b0});
    @(negedge clk); #1;
    chk("stray_err_pulse", {29'd0, oError, oDone, oDecipherStart}, 32'd0);
    iDecipherDone = 1'b1;
    @(negedge clk); iDecipherDone = 1'b0; #1;
    chk("stray_then_done", {30'd0, oDone, oError}, {30'd0, 1'b1, 1'b0});
    @(negedge clk); #1;
    chk("stray_idle", {31'd0, oBusy}, 32'd0);

    // Rekey job: expander writes, cipher reads, then reset lands mid-run
    iStart = 1'b1; iMode = 2'b00; iRekey = 1'b1;
    @(negedge clk); iStart = 1'b0; iRekey = 1'b0; #1;
    chk("rekey_clears_kv", {29'd0, oKeyValid, oOwner}, {29'd0, 1'b0, 2'd1});
    @(negedge clk);
    @(negedge clk);
    iS_addr_exp = 5'd5; iS_we_exp = 1'b1; #1;
    chk("exp_ports", {20'd0, oExpandStart, oS_addr_a, oS_addr_b, oS_we_a},
        {20'd0, 1'b1, 5'd5, 5'd0, 1'b1});
    iExpandDone = 1'b1;
    @(negedge clk); iExpandDone = 1'b0; #1;
    chk("kv_after_exp", {29'd0, oKeyValid, oOwner}, {29'd0, 1'b1, 2'd2});
    @(negedge clk);
    @(negedge clk);
    iS_addr_ciph1 = 5'd3; iS_addr_ciph2 = 5'd7; iS_we_exp = 1'b1; #1;
    chk("ciph_ports", {20'd0, oCipherStart, oS_addr_a, oS_addr_b, oS_we_a},
        {20'd0, 1'b1, 5'd3, 5'd7, 1'b0});
    @(negedge clk); #2;
    rst = 1'b0; #1;
    chk("async_rst_ctrl", {23'd0, oBusy, oDone, oError, oKeyValid, oOwner,
                           oExpandStart, oCipherStart, oDecipherStart}, 32'd0);
    chk("async_rst_mux", {21'd0, oS_addr_a, oS_addr_b, oS_we_a}, 32'd0);
    @(negedge clk); #1;
    chk("rst_no_done", {31'd0, oDone}, 32'd0);
    rst = 1'b1;
    kv_model = 1'b0;

    // After reset the key is stale, so the next job must expand again
    run_job(2'b00, 1'b0, 1, 3, 0, 1'b0, bc);

    // Randomized jobs against the timeline model
    for (int r = 0; r < 24; r++) begin
      run_job(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
              $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12), 1'b1, bc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
